// File: rtl/pmp_checker.sv
// PMP checker: ENTRIES cfg/addr pairs with OFF/TOR/NA4/NAPOT matching, locks and permission evaluation.
// Latency: one registered stage for the check response; CSR writes land on the next edge; CSR reads registered.
// Backpressure: none; one check accepted every cycle, back-to-back requests give back-to-back responses.
module pmp_checker #(
  parameter int ENTRIES = 8,
  parameter int PA_W    = 32
) (
  input  logic            cpu_clock_i,
  input  logic            cpu_reset_i,
  input  logic            csr_we_i,
  input  logic            csr_is_cfg_i,
  input  logic [3:0]      csr_idx_i,
  input  logic [PA_W-3:0] csr_wdata_i,
  output logic [PA_W-3:0] csr_rdata_o,
  input  logic            req_valid_i,
  input  logic [PA_W-1:0] req_addr_i,
  input  logic [1:0]      req_type_i,
  input  logic            req_mmode_i,
  output logic            resp_valid_o,
  output logic            resp_fault_o,
  output logic            resp_hit_o,
  output logic [3:0]      resp_entry_o
);

  localparam int AW = PA_W - 2;

  logic [7:0]    cfg  [ENTRIES];
  logic [AW-1:0] addr [ENTRIES];

  logic [AW-1:0]      word;
  logic               unused_addr_lsb;
  logic [7:0]         cfg_wr;
  logic [ENTRIES-1:0] addr_lock;
  logic [ENTRIES-1:0] match;

  // Checks are word granular; the byte offset never takes part in matching.
  assign word            = req_addr_i[PA_W-1:2];
  assign unused_addr_lsb = ^req_addr_i[1:0];

  // Legalised cfg byte: bits [6:5] forced to 0, W without R stored as W=0.
  assign cfg_wr = {csr_wdata_i[7], 2'b00, csr_wdata_i[4:2],
                   csr_wdata_i[1] & csr_wdata_i[0], csr_wdata_i[0]};

  for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
    logic [AW-1:0] base;
    logic [AW-1:0] napot_mask;
    logic          tor_hit;
    logic          na4_hit;
    logic          napot_hit;

    // TOR base is the previous entry's addr, or 0 for entry 0.
    if (g == 0) begin : g_base_zero
      assign base = '0;
    end else begin : g_base_prev
      assign base = addr[g-1];
    end

    // An addr register is frozen by its own lock, or by a locked TOR entry above that uses it as base.
    if (g == ENTRIES - 1) begin : g_lock_last
      assign addr_lock[g] = cfg[g][7];
    end else begin : g_lock_mid
      assign addr_lock[g] = cfg[g][7] | (cfg[g+1][7] & (cfg[g+1][4:3] == 2'd1));
    end

    // addr ^ (addr+1) sets the trailing-ones run plus the next bit; its complement is the NAPOT mask.
    // All-ones addr wraps to a zero mask and so matches everything.
    assign napot_mask = ~(addr[g] ^ (addr[g] + AW'(1)));
    assign tor_hit    = (word >= base) && (word < addr[g]);
    assign na4_hit    = (word == addr[g]);
    assign napot_hit  = ((word ^ addr[g]) & napot_mask) == '0;

    assign match[g] = (cfg[g][4:3] == 2'd1) ? tor_hit   :
                      (cfg[g][4:3] == 2'd2) ? na4_hit   :
                      (cfg[g][4:3] == 2'd3) ? napot_hit : 1'b0;
  end

  logic          hit;
  logic [3:0]    win;
  logic [7:0]    win_cfg;
  logic          perm;
  logic          fault;
  logic [AW-1:0] rd_mux;

  // Lowest-index match wins (scan from the top so the lowest hit is assigned last), then evaluate permission.
  always_comb begin
    hit     = 1'b0;
    win     = '0;
    win_cfg = '0;
    perm    = 1'b0;
    fault   = 1'b0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit     = 1'b1;
        win     = 4'(i);
        win_cfg = cfg[i];
      end
    end
    case (req_type_i)
      2'd0:    perm = win_cfg[0];
      2'd1:    perm = win_cfg[1];
      2'd2:    perm = win_cfg[2];
      default: perm = 1'b0;
    endcase
    if (hit) fault = req_mmode_i ? (win_cfg[7] & ~perm) : ~perm;
    else     fault = ~req_mmode_i;
  end

  // CSR read mux; out-of-range indices read as zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (csr_idx_i == 4'(i)) rd_mux = csr_is_cfg_i ? {{(AW-8){1'b0}}, cfg[i]} : addr[i];
    end
  end

  // Table update: writes honour locks and only lock-free reset clears a locked entry.
  always_ff @(posedge cpu_clock_i) begin
    if (cpu_reset_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        cfg[i]  <= '0;
        addr[i] <= '0;
      end
    end else if (csr_we_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (csr_idx_i == 4'(i)) begin
          if (csr_is_cfg_i) begin
            if (!cfg[i][7]) cfg[i] <= cfg_wr;
          end else if (!addr_lock[i]) begin
            addr[i] <= csr_wdata_i;
          end
        end
      end
    end
  end

  // Response register: valid pulses per request, result fields hold between requests.
  always_ff @(posedge cpu_clock_i) begin
    if (cpu_reset_i) begin
      resp_valid_o <= 1'b0;
      resp_fault_o <= 1'b0;
      resp_hit_o   <= 1'b0;
      resp_entry_o <= '0;
    end else begin
      resp_valid_o <= req_valid_i;
      if (req_valid_i) begin
        resp_fault_o <= fault;
        resp_hit_o   <= hit;
        resp_entry_o <= win;
      end
    end
  end

  // Registered CSR readback.
  always_ff @(posedge cpu_clock_i) begin
    if (cpu_reset_i) csr_rdata_o <= '0;
    else             csr_rdata_o <= rd_mux;
  end

endmodule

// File: tb/tb_pmp_checker.sv
// Bench for pmp_checker: directed scenarios plus randomized traffic against a behavioural model.
// Expected responses go into a scoreboard queue; an independent monitor pops and compares.
// CSR readback is compared one cycle after each index is presented.
module tb_pmp_checker;

  localparam int E = 8;

  typedef struct packed {
    logic       fault;
    logic       hit;
    logic [3:0] entry;
  } exp_t;

  logic        clk;
  logic        cpu_reset_i;
  logic        csr_we_i;
  logic        csr_is_cfg_i;
  logic [3:0]  csr_idx_i;
  logic [29:0] csr_wdata_i;
  logic [29:0] csr_rdata_o;
  logic        req_valid_i;
  logic [31:0] req_addr_i;
  logic [1:0]  req_type_i;
  logic        req_mmode_i;
  logic        resp_valid_o;
  logic        resp_fault_o;
  logic        resp_hit_o;
  logic [3:0]  resp_entry_o;

  pmp_checker #(.ENTRIES(E), .PA_W(32)) dut (
    .cpu_clock_i (clk),
    .cpu_reset_i (cpu_reset_i),
    .csr_we_i    (csr_we_i),
    .csr_is_cfg_i(csr_is_cfg_i),
    .csr_idx_i   (csr_idx_i),
    .csr_wdata_i (csr_wdata_i),
    .csr_rdata_o (csr_rdata_o),
    .req_valid_i (req_valid_i),
    .req_addr_i  (req_addr_i),
    .req_type_i  (req_type_i),
    .req_mmode_i (req_mmode_i),
    .resp_valid_o(resp_valid_o),
    .resp_fault_o(resp_fault_o),
    .resp_hit_o  (resp_hit_o),
    .resp_entry_o(resp_entry_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  logic [7:0]  m_cfg  [16];
  logic [29:0] m_addr [16];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_cfg[i]  = 8'h00;
      m_addr[i] = '0;
    end
  endfunction

  function automatic void model_write(logic is_cfg, int idx, logic [29:0] wd);
    logic [7:0] c;
    if (idx >= E) return;
    if (is_cfg) begin
      if (m_cfg[idx][7]) return;
      c = wd[7:0];
      c[6:5] = 2'b00;
      if (c[1] && !c[0]) c[1] = 1'b0;
      m_cfg[idx] = c;
    end else begin
      if (m_cfg[idx][7]) return;
      if (idx + 1 < E && m_cfg[idx+1][7] && m_cfg[idx+1][4:3] == 2'd1) return;
      m_addr[idx] = wd;
    end
  endfunction

  function automatic logic [29:0] model_read(logic is_cfg, logic [3:0] idx);
    if (int'(idx) >= E) return '0;
    return is_cfg ? {22'd0, m_cfg[idx]} : m_addr[idx];
  endfunction

  // Region arithmetic on word addresses: TOR range, single word, or aligned power-of-two block.
  function automatic exp_t model_check(logic [31:0] ad, logic [1:0] ty, logic mm);
    exp_t       r;
    longint     a, top, base, blk;
    int         t;
    bit         m;
    logic       perm;
    logic [7:0] c;
    r = '0;
    a = longint'(ad >> 2);
    for (int i = 0; i < E; i++) begin
      if (!r.hit) begin
        m   = 0;
        top = longint'(m_addr[i]);
        case (m_cfg[i][4:3])
          2'd1: begin
            base = 0;
            if (i > 0) base = longint'(m_addr[i-1]);
            m = (a >= base) && (a < top);
          end
          2'd2: m = (a == top);
          2'd3: begin
            t = 0;
            while (t < 30 && m_addr[i][t]) t++;
            blk  = longint'(1) << (t + 1);
            base = (top / blk) * blk;
            m = (a >= base) && (a < base + blk);
          end
          default: m = 0;
        endcase
        if (m) begin
          r.hit   = 1'b1;
          r.entry = 4'(i);
        end
      end
    end
    c = m_cfg[r.entry];
    case (ty)
      2'd0:    perm = c[0];
      2'd1:    perm = c[1];
      2'd2:    perm = c[2];
      default: perm = 1'b0;
    endcase
    if (r.hit) r.fault = mm ? (c[7] & ~perm) : ~perm;
    else       r.fault = ~mm;
    return r;
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic rst, input logic we, input logic is_cfg, input logic [3:0] idx,
                      input logic [29:0] wd, input logic rv, input logic [31:0] ad,
                      input logic [1:0] ty, input logic mm, input logic fixed, input exp_t fx);
    exp_t        e;
    logic [29:0] erd;
    cpu_reset_i  = rst;
    csr_we_i     = we;
    csr_is_cfg_i = is_cfg;
    csr_idx_i    = idx;
    csr_wdata_i  = wd;
    req_valid_i  = rv;
    req_addr_i   = ad;
    req_type_i   = ty;
    req_mmode_i  = mm;
    e   = fixed ? fx : model_check(ad, ty, mm);
    erd = rst ? '0 : model_read(is_cfg, idx);
    @(posedge clk);
    if (rv && !rst) sb.push_back(e);
    if (rst) model_reset();
    else if (we) model_write(is_cfg, int'(idx), wd);
    #1;
    chk("csr_rdata", 32'(csr_rdata_o), 32'(erd));
  endtask

  task automatic idle();
    step(0, 0, 0, 4'd0, '0, 0, '0, 2'd0, 0, 0, '0);
  endtask

  task automatic rst_step();
    step(1, 0, 0, 4'd0, '0, 0, '0, 2'd0, 0, 0, '0);
  endtask

  task automatic wr_cfg(input logic [3:0] idx, input logic [7:0] v);
    step(0, 1, 1, idx, {22'd0, v}, 0, '0, 2'd0, 0, 0, '0);
  endtask

  task automatic wr_addr(input logic [3:0] idx, input logic [29:0] v);
    step(0, 1, 0, idx, v, 0, '0, 2'd0, 0, 0, '0);
  endtask

  task automatic rd_chk(string name, input logic is_cfg, input logic [3:0] idx, input logic [29:0] v);
    step(0, 0, is_cfg, idx, '0, 0, '0, 2'd0, 0, 0, '0);
    chk(name, 32'(csr_rdata_o), 32'(v));
  endtask

  task automatic req(input logic [31:0] ad, input logic [1:0] ty, input logic mm,
                     input logic f, input logic h, input logic [3:0] en);
    exp_t x;
    x.fault = f;
    x.hit   = h;
    x.entry = en;
    step(0, 0, 0, 4'd0, '0, 1, ad, ty, mm, 1, x);
  endtask

  // ---------------- monitor ----------------
  exp_t held;
  logic rst_q;

  initial begin
    exp_t e;
    held = '0;
    forever begin
      @(posedge clk);
      rst_q = cpu_reset_i;
      @(negedge clk);
      if (rst_q) begin
        chk("reset_resp_valid", 32'(resp_valid_o), 32'd0);
        chk("reset_resp_fault", 32'(resp_fault_o), 32'd0);
        chk("reset_resp_hit",   32'(resp_hit_o),   32'd0);
        chk("reset_resp_entry", 32'(resp_entry_o), 32'd0);
        held = '0;
      end else if (resp_valid_o) begin
        if (sb.size() == 0) begin
          chk("unexpected_resp", 32'(resp_valid_o), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("resp_fault", 32'(resp_fault_o), 32'(e.fault));
          chk("resp_hit",   32'(resp_hit_o),   32'(e.hit));
          chk("resp_entry", 32'(resp_entry_o), 32'(e.entry));
          held = e;
        end
      end else if (sb.size() != 0) begin
        chk("missing_resp", 32'(resp_valid_o), 32'd1);
        void'(sb.pop_front());
      end else begin
        chk("hold_fault", 32'(resp_fault_o), 32'(held.fault));
        chk("hold_hit",   32'(resp_hit_o),   32'(held.hit));
        chk("hold_entry", 32'(resp_entry_o), 32'(held.entry));
      end
    end
  end

  // ---------------- stimulus ----------------
  logic        r_rst, r_we, r_ic, r_rv, r_mm;
  logic [3:0]  r_idx;
  logic [29:0] r_wd;
  logic [31:0] r_ad;
  logic [1:0]  r_ty;

  initial begin
    model_reset();
    rst_step();
    rst_step();
    rd_chk("reset_cfg0", 1, 4'd0, 30'h0);
    rd_chk("reset_addr0", 0, 4'd0, 30'h0);

    // NAPOT 4 KiB at 0x00080000
    wr_addr(4'd0, 30'h000201FF);
    wr_cfg(4'd0, 8'h1B);
    rd_chk("napot_cfg_readback", 1, 4'd0, 30'h1B);
    req(32'h00080FFC, 2'd0, 0, 0, 1, 4'd0);
    req(32'h00081000, 2'd0, 0, 1, 0, 4'd0);
    req(32'h00080000, 2'd1, 0, 0, 1, 4'd0);

    // TOR with implicit zero base
    rst_step();
    wr_addr(4'd0, 30'h00000400);
    wr_cfg(4'd0, 8'h0D);
    req(32'h00000FFC, 2'd2, 0, 0, 1, 4'd0);
    req(32'h00001000, 2'd2, 0, 1, 0, 4'd0);
    req(32'h00000010, 2'd1, 0, 1, 1, 4'd0);

    // Priority and M-mode lock semantics
    rst_step();
    wr_addr(4'd0, 30'h00004000);
    wr_cfg(4'd0, 8'h90);
    wr_addr(4'd1, 30'h00004001);
    wr_cfg(4'd1, 8'h1F);
    req(32'h00010000, 2'd0, 1, 1, 1, 4'd0);
    req(32'h00010004, 2'd0, 1, 0, 1, 4'd1);
    wr_cfg(4'd0, 8'h10);
    rd_chk("locked_cfg_kept", 1, 4'd0, 30'h90);
    wr_addr(4'd0, 30'h5555);
    rd_chk("locked_addr_kept", 0, 4'd0, 30'h4000);

    // Locked TOR entry freezes its base register
    rst_step();
    wr_addr(4'd0, 30'h100);
    wr_addr(4'd1, 30'h200);
    wr_cfg(4'd1, 8'h89);
    wr_addr(4'd0, 30'h123);
    rd_chk("tor_base_locked", 0, 4'd0, 30'h100);
    wr_addr(4'd2, 30'h300);
    rd_chk("tor_next_writable", 0, 4'd2, 30'h300);
    req(32'h00000400, 2'd0, 0, 0, 1, 4'd1);
    req(32'h00000400, 2'd1, 0, 1, 1, 4'd1);
    req(32'h000003FC, 2'd0, 0, 1, 0, 4'd0);

    // Write/check collision: check sees pre-write cfg
    rst_step();
    wr_addr(4'd0, 30'h000201FF);
    wr_cfg(4'd0, 8'h18);
    begin
      exp_t x;
      x = '{fault: 1'b1, hit: 1'b1, entry: 4'd0};
      step(0, 1, 1, 4'd0, 30'h1F, 1, 32'h00080000, 2'd0, 0, 1, x);
    end
    req(32'h00080000, 2'd0, 0, 0, 1, 4'd0);

    // Reset mid-stream, reserved encodings, out-of-range index
    req(32'h00080004, 2'd0, 0, 0, 1, 4'd0);
    rst_step();
    chk("reset_drops_valid", 32'(resp_valid_o), 32'd0);
    for (int i = 0; i < E; i++) rd_chk("cfg_after_reset", 1, 4'(i), 30'h0);
    wr_cfg(4'd0, 8'h1A);
    rd_chk("w_without_r", 1, 4'd0, 30'h18);
    wr_cfg(4'd9, 8'h1F);
    rd_chk("out_of_range_read", 1, 4'd9, 30'h0);
    wr_addr(4'd0, 30'h3FFFFFFF);
    wr_cfg(4'd0, 8'h1F);
    req(32'h00001234, 2'd3, 0, 1, 1, 4'd0);
    req(32'h00001234, 2'd3, 1, 0, 1, 4'd0);
    req(32'hFFFFFFFC, 2'd2, 0, 0, 1, 4'd0);
    idle();
    idle();

    // Randomized traffic against the model
    rst_step();
    for (int n = 0; n < 3000; n++) begin
      r_rst = ($urandom_range(0, 299) == 0);
      r_we  = ($urandom_range(0, 2) == 0);
      r_ic  = 1'($urandom_range(0, 1));
      r_idx = 4'($urandom_range(0, 9));
      if (r_ic) begin
        r_wd = 30'($urandom_range(0, 255));
        if ($urandom_range(0, 31) != 0) r_wd[7] = 1'b0;
      end else begin
        case ($urandom_range(0, 3))
          0:       r_wd = 30'h3FFFFFFF;
          1:       r_wd = 30'($urandom_range(0, 63));
          default: r_wd = 30'($urandom_range(0, 127));
        endcase
      end
      r_rv = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) r_ad = $urandom & 32'hFFFFFFFC;
      else                           r_ad = 32'($urandom_range(0, 140)) << 2;
      r_ty = 2'($urandom_range(0, 3));
      r_mm = 1'($urandom_range(0, 1));
      step(r_rst, r_we, r_ic, r_idx, r_wd, r_rv, r_ad, r_ty, r_mm, 0, '0);
    end
    idle();
    idle();
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
